// File: rtl/fpu_unpack_sequencer_pkg.sv
// Shared types for the FP operand unpack sequencer: unpacked-operand record,
// sequencer state encoding and the double-precision format constants.
package fpu_unpack_pkg;

    localparam int FLEN         = 64;
    localparam int NE           = 11;
    localparam int NF           = 52;
    localparam int FMTBITS      = 2;
    localparam int NOPS_DEFAULT = 3;

    // One unpacked operand as produced by the shared unpack unit.
    typedef struct packed {
        logic            Sgn;
        logic [NE-1:0]   Exp;
        logic [NF:0]     Man;
        logic            NaN;
        logic            SNaN;
        logic            Zero;
        logic            Inf;
        logic            ExpMax;
        logic            Subnorm;
        logic [FLEN-1:0] PostBox;
    } unpack_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        DONE   = 2'd2
    } unpseq_state_t;

endpackage

// File: rtl/fpu_unpack_sequencer_opsel.sv
// Operand selector: picks the lowest pending slot and returns its index plus
// a one-hot mask that clears exactly that slot from the pending set.
module unpack_opsel #(
    parameter int NOPS = 3,
    localparam int IW  = (NOPS > 1) ? $clog2(NOPS) : 1
) (
    input  logic [NOPS-1:0] pending,
    output logic [IW-1:0]   idx,
    output logic [NOPS-1:0] clr_mask
);

    // below[i] is set when some slot under i is still pending
    logic [NOPS-1:0] below;

    assign below[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NOPS; gi++) begin : g_below
            assign below[gi] = below[gi-1] | pending[gi-1];
        end
        for (gi = 0; gi < NOPS; gi++) begin : g_onehot
            assign clr_mask[gi] = pending[gi] & ~below[gi];
        end
    endgenerate

    // Encode the one-hot winner into a slot index (zero when nothing pending)
    always_comb begin
        idx = '0;
        for (int i = 0; i < NOPS; i++) begin
            if (clr_mask[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/fpu_unpack_sequencer.sv
// Time-multiplexes one shared single-operand unpack unit over up to NOPS
// source operands. A bundle is accepted with valid/ready, masked operands are
// unpacked one per cycle in slot order, and the registered result set is
// presented with valid/ready. A bundle can be taken in the same cycle the
// previous result set is consumed, so back-to-back bundles leave no bubble.
module fpu_unpack_sequencer
    import fpu_unpack_pkg::*;
#(
    parameter int NOPS = NOPS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           Flush,
    input  logic                           InValid,
    output logic                           InReady,
    input  logic [NOPS-1:0][FLEN-1:0]      Ops,
    input  logic [NOPS-1:0]                OpMask,
    input  logic [FMTBITS-1:0]             Fmt,
    output logic [FLEN-1:0]                UnpA,
    output logic                           UnpEn,
    output logic [FMTBITS-1:0]             UnpFmt,
    input  unpack_t                        UnpRes,
    output logic                           OutValid,
    input  logic                           OutReady,
    output unpack_t [NOPS-1:0]             Res,
    output logic                           Busy
);

    localparam int IW = (NOPS > 1) ? $clog2(NOPS) : 1;

    unpseq_state_t              state_reg;
    logic [NOPS-1:0]            pending_reg;
    logic [NOPS-1:0][FLEN-1:0]  op_reg;
    logic [FMTBITS-1:0]         fmt_reg;
    unpack_t [NOPS-1:0]         res_reg;
    logic                       outvalid_reg;

    logic [IW-1:0]              sel_idx;
    logic [NOPS-1:0]            sel_clr;
    logic [NOPS-1:0]            pending_next;
    logic                       accept;

    unpack_opsel #(
        .NOPS(NOPS)
    ) u_opsel (
        .pending  (pending_reg),
        .idx      (sel_idx),
        .clr_mask (sel_clr)
    );

    assign pending_next = pending_reg & ~sel_clr;

    // Ready when idle, or when the finished set is being consumed this cycle
    assign InReady = (state_reg == IDLE) | ((state_reg == DONE) & OutReady);
    assign accept  = InValid & InReady;

    // Shared unpack unit is only driven while a slot is being unpacked
    assign UnpEn    = (state_reg == UNPACK);
    assign UnpA     = UnpEn ? op_reg[sel_idx] : '0;
    assign UnpFmt   = fmt_reg;

    assign OutValid = outvalid_reg;
    assign Res      = res_reg;
    assign Busy     = (state_reg != IDLE);

    // Sequencer: reset beats flush, flush beats accept and the output handshake
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            op_reg       <= '0;
            fmt_reg      <= '0;
            res_reg      <= '0;
            outvalid_reg <= 1'b0;
        end else if (Flush) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            outvalid_reg <= 1'b0;
        end else if (accept) begin
            op_reg       <= Ops;
            fmt_reg      <= Fmt;
            pending_reg  <= OpMask;
            res_reg      <= '0;
            // An empty mask has nothing to unpack and completes immediately
            state_reg    <= (OpMask == '0) ? DONE : UNPACK;
            outvalid_reg <= (OpMask == '0);
        end else begin
            case (state_reg)
                UNPACK: begin
                    res_reg[sel_idx] <= UnpRes;
                    pending_reg      <= pending_next;
                    if (pending_next == '0) begin
                        state_reg    <= DONE;
                        outvalid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state_reg    <= IDLE;
                        outvalid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_unpack_sequencer.sv
// Bench for fpu_unpack_sequencer: a queue-based transaction model is compared
// against the DUT every cycle, directed scenarios add literal expectations.
module tb_fpu_unpack_sequencer;
    import fpu_unpack_pkg::*;

    localparam int N = 3;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      Flush;
    logic                      InValid;
    logic                      InReady;
    logic [N-1:0][FLEN-1:0]    Ops;
    logic [N-1:0]              OpMask;
    logic [FMTBITS-1:0]        Fmt;
    logic [FLEN-1:0]           UnpA;
    logic                      UnpEn;
    logic [FMTBITS-1:0]        UnpFmt;
    unpack_t                   UnpRes;
    logic                      OutValid;
    logic                      OutReady;
    unpack_t [N-1:0]           Res;
    logic                      Busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_unpack_sequencer #(.NOPS(N)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .Ops      (Ops),
        .OpMask   (OpMask),
        .Fmt      (Fmt),
        .UnpA     (UnpA),
        .UnpEn    (UnpEn),
        .UnpFmt   (UnpFmt),
        .UnpRes   (UnpRes),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Res      (Res),
        .Busy     (Busy)
    );

    always #5 clk = ~clk;

    // Reference double-precision unpack, also serving as the shared unit
    function automatic unpack_t unp(input logic [FLEN-1:0] a);
        unpack_t         u;
        logic [NE-1:0]   e;
        logic [NF-1:0]   f;
        e         = a[FLEN-2 -: NE];
        f         = a[NF-1:0];
        u.Sgn     = a[FLEN-1];
        u.Exp     = e;
        u.Man     = {(e != '0), f};
        u.ExpMax  = (e == '1);
        u.NaN     = u.ExpMax && (f != '0);
        u.SNaN    = u.NaN && !f[NF-1];
        u.Inf     = u.ExpMax && (f == '0);
        u.Zero    = (e == '0) && (f == '0);
        u.Subnorm = (e == '0) && (f != '0);
        u.PostBox = a;
        return u;
    endfunction

    assign UnpRes = unp(UnpA);

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_bundle(input logic [N-1:0] mask, input logic [FLEN-1:0] x,
                                 input logic [FLEN-1:0] y, input logic [FLEN-1:0] z);
        InValid = 1'b1;
        OpMask  = mask;
        Fmt     = 2'b01;
        Ops[0]  = x;
        Ops[1]  = y;
        Ops[2]  = z;
        cyc();
        // inputs need not be held after the accept edge
        InValid = 1'b0;
        OpMask  = 3'b111;
        Fmt     = 2'b11;
        Ops[0]  = 64'hDEADBEEFCAFEF00D;
        Ops[1]  = 64'hDEADBEEFCAFEF00D;
        Ops[2]  = 64'hDEADBEEFCAFEF00D;
    endtask

    task automatic wait_outvalid(input string name, input int max);
        int c = 0;
        while (OutValid !== 1'b1 && c < max) begin
            cyc();
            c++;
        end
        n_tests++;
        if (OutValid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: OutValid got %b expected 1 within %0d cycles", name, OutValid, max);
        end
    endtask

    // ---------------- transaction model + per-cycle compare ----------------
    bit                       m_active;
    int                       m_q[$];
    logic [N-1:0][FLEN-1:0]   m_ops;
    logic [FMTBITS-1:0]       m_fmt;
    unpack_t [N-1:0]          m_res;

    initial begin
        bit              e_outvalid, e_unpen, e_inready, acc;
        logic [FLEN-1:0] e_unpa;
        int              k;
        m_active = 1'b0;
        m_ops    = '0;
        m_fmt    = '0;
        m_res    = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_outvalid = m_active && (m_q.size() == 0);
            e_unpen    = m_active && (m_q.size() != 0);
            e_unpa     = e_unpen ? m_ops[m_q[0]] : '0;
            e_inready  = !m_active || (e_outvalid && OutReady);
            check("m_outvalid", OutValid, e_outvalid);
            check("m_busy", Busy, m_active);
            check("m_unpen", UnpEn, e_unpen);
            check("m_unpa", UnpA, e_unpa);
            check("m_inready", InReady, e_inready);
            if (e_unpen) check("m_unpfmt", UnpFmt, m_fmt);
            for (int i = 0; i < N; i++) check($sformatf("m_res%0d", i), Res[i], m_res[i]);
            // advance to the state after the coming edge
            if (!reset_n) begin
                m_active = 1'b0;
                m_q.delete();
                m_res = '0;
            end else if (Flush) begin
                m_active = 1'b0;
                m_q.delete();
            end else begin
                acc = InValid && e_inready;
                if (e_unpen) begin
                    k = m_q.pop_front();
                    m_res[k] = unp(m_ops[k]);
                end else if (e_outvalid && OutReady && !acc) begin
                    m_active = 1'b0;
                end
                if (acc) begin
                    m_active = 1'b1;
                    m_ops    = Ops;
                    m_fmt    = Fmt;
                    m_res    = '0;
                    m_q.delete();
                    for (int i = 0; i < N; i++) if (OpMask[i]) m_q.push_back(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    localparam logic [FLEN-1:0] ONE  = 64'h3FF0000000000000;
    localparam logic [FLEN-1:0] TWO  = 64'h4000000000000000;
    localparam logic [FLEN-1:0] MTWO = 64'hC000000000000000;
    localparam logic [FLEN-1:0] PINF = 64'h7FF0000000000000;
    localparam logic [FLEN-1:0] QNAN = 64'h7FF8000000000000;
    localparam logic [FLEN-1:0] SNAN = 64'h7FF4000000000000;

    logic [FLEN-1:0] vals [6];
    logic [N-1:0]    masks [5];
    unpack_t         pin;

    initial begin
        reset_n  = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Ops      = '0;
        OpMask   = '0;
        Fmt      = '0;
        vals  = '{ONE, PINF, QNAN, SNAN, 64'h0000000000000001, 64'h8000000000000000};
        masks = '{3'b110, 3'b001, 3'b000, 3'b111, 3'b010};

        // pin the reference unpack on literal values
        pin = unp(ONE);
        check("pin_one_exp", pin.Exp, 11'h3FF);
        check("pin_one_man", pin.Man, 53'h10000000000000);
        pin = unp(SNAN);
        check("pin_snan", {pin.NaN, pin.SNaN, pin.Inf}, 3'b110);
        pin = unp(64'h0);
        check("pin_zero", {pin.Zero, pin.Subnorm}, 2'b10);

        // reset held two cycles
        cyc();
        cyc();
        check("rst_outvalid", OutValid, 1'b0);
        check("rst_inready", InReady, 1'b1);
        check("rst_busy", Busy, 1'b0);
        check("rst_unpen", UnpEn, 1'b0);
        check("rst_res", Res, '0);
        reset_n = 1'b1;

        // single operand X
        accept_bundle(3'b001, ONE, 64'h0, 64'h0);
        check("x_unpen", UnpEn, 1'b1);
        check("x_unpa", UnpA, ONE);
        check("x_outvalid_early", OutValid, 1'b0);
        cyc();
        check("x_outvalid", OutValid, 1'b1);
        check("x_res0_exp", Res[0].Exp, 11'h3FF);
        check("x_res0_man", Res[0].Man, 53'h10000000000000);
        check("x_res1", Res[1], '0);
        check("x_res2", Res[2], '0);
        OutReady = 1'b1;
        cyc();
        OutReady = 1'b0;

        // X and Z, Y skipped
        accept_bundle(3'b101, ONE, TWO, PINF);
        check("xz_unpa1", UnpA, ONE);
        cyc();
        check("xz_unpa2", UnpA, PINF);
        cyc();
        check("xz_outvalid", OutValid, 1'b1);
        check("xz_res2_inf", Res[2].Inf, 1'b1);
        check("xz_res1", Res[1], '0);
        OutReady = 1'b1;
        cyc();
        OutReady = 1'b0;

        // empty mask completes in one cycle
        accept_bundle(3'b000, ONE, TWO, PINF);
        check("m0_outvalid", OutValid, 1'b1);
        check("m0_unpen", UnpEn, 1'b0);
        check("m0_res", Res, '0);
        OutReady = 1'b1;
        cyc();
        OutReady = 1'b0;

        // hold in DONE, then hand over to a new bundle with no bubble
        accept_bundle(3'b011, TWO, ONE, 64'h0);
        wait_outvalid("hold_done", 10);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold_outvalid", OutValid, 1'b1);
            check("hold_res1_exp", Res[1].Exp, 11'h3FF);
            check("hold_res0_exp", Res[0].Exp, 11'h400);
        end
        OutReady = 1'b1;
        #1;
        check("b2b_inready", InReady, 1'b1);
        accept_bundle(3'b001, MTWO, 64'h0, 64'h0);
        check("b2b_unpen", UnpEn, 1'b1);
        check("b2b_unpa", UnpA, MTWO);
        check("b2b_outvalid", OutValid, 1'b0);
        cyc();
        check("b2b_done", OutValid, 1'b1);
        check("b2b_res0", {Res[0].Sgn, Res[0].Exp}, {1'b1, 11'h400});
        cyc();
        OutReady = 1'b0;

        // flush in the second unpack cycle
        accept_bundle(3'b111, ONE, TWO, PINF);
        cyc();
        Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        check("fl_busy", Busy, 1'b0);
        check("fl_outvalid", OutValid, 1'b0);
        check("fl_inready", InReady, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("fl_stays_low", OutValid, 1'b0);
        end
        accept_bundle(3'b010, 64'h0, QNAN, 64'h0);
        wait_outvalid("fl_next", 10);
        check("fl_next_nan", {Res[1].NaN, Res[1].SNaN}, 2'b10);

        // flush beats both the output handshake and a new accept
        OutReady = 1'b1;
        InValid  = 1'b1;
        OpMask   = 3'b001;
        Ops[0]   = ONE;
        Flush    = 1'b1;
        cyc();
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        check("flh_busy", Busy, 1'b0);
        check("flh_res1_kept", Res[1].NaN, 1'b1);

        // reset mid-unpack overrides flush and clears results
        accept_bundle(3'b111, ONE, TWO, PINF);
        cyc();
        reset_n = 1'b0;
        Flush   = 1'b1;
        cyc();
        reset_n = 1'b1;
        Flush   = 1'b0;
        check("rmid_res", Res, '0);
        check("rmid_busy", Busy, 1'b0);

        // back-to-back bundles with the consumer always ready
        OutReady = 1'b1;
        for (int b = 0; b < 5; b++) begin
            int c;
            InValid = 1'b1;
            OpMask  = masks[b];
            Fmt     = 2'(b);
            for (int j = 0; j < N; j++) Ops[j] = vals[(b + j) % 6];
            c = 0;
            while (!InReady && c < 10) begin
                cyc();
                c++;
            end
            check("bb_ready", InReady, 1'b1);
            cyc();
        end
        InValid = 1'b0;
        wait_outvalid("bb_last", 10);
        cyc();
        OutReady = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
